if_stage: RTL and testbench

// - Instruction-fetch stage of the 5-stage MIPS pipeline. It is the reader side of the

---
 rtl/mips_defs_pkg.sv | 23 ++
 rtl/pc_reg.sv | 35 +++
 rtl/if_stage.sv | 81 ++++++++
 tb/tb_if_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// rtl/mips_defs_pkg.sv - shared MIPS pipeline constants and fetch-window helper
package mips_defs_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam int          IM_AW_DEF    = 10;
    localparam logic [31:0] NOP_DEF      = 32'h0000_0000;

    // Exception code reported for an instruction-fetch address error (AdEL).
    localparam logic [4:0]  EXC_IF_FETCH = 5'd4;

    // A fetch faults when the PC is not word aligned or lies outside the
    // instruction-memory window that contains the reset PC.
    function automatic logic fetch_fault(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input int          aw);
        logic [31:0] pc_hi;
        logic [31:0] base_hi;
        pc_hi   = pc >> (aw + 2);
        base_hi = base >> (aw + 2);
        return (pc[1:0] != 2'b00) || (pc_hi != base_hi);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - fetch PC register with stall/redirect selection and fault check
//
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   stall            hold the PC
//   redirect, target load target instead of pc+4 (ignored while stalled)
//   pc               current fetch PC
//   fault            current PC is misaligned or outside the fetch window
module pc_reg
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          IM_AW    = IM_AW_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic        fault
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= PC_RESET;
        end else if (!stall) begin
            // A redirect seen during a stall is dropped; D re-asserts it later.
            pc <= redirect ? target : pc + 32'd4;
        end
    end

    assign fault = fetch_fault(pc, PC_RESET, IM_AW);

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage with IF/ID register and fetch counter
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   stall             hold PC and IF/ID
//   flush             clear IF/ID to NOP / valid 0 on next edge
//   redirect, target  branch/jump redirect of the fetch PC
//   im_addr, im_instr combinational instruction-memory read port
//   pc_f              current fetch PC
//   instr_d, pc_d, pc8_d, valid_d, fault_d   IF/ID register contents
//   fetch_cnt         number of valid instructions loaded into IF/ID
module if_stage
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          IM_AW    = IM_AW_DEF,
    parameter logic [31:0] NOP      = NOP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect,
    input  logic [31:0]      target,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_instr,
    output logic [31:0]      pc_f,
    output logic [31:0]      instr_d,
    output logic [31:0]      pc_d,
    output logic [31:0]      pc8_d,
    output logic             valid_d,
    output logic             fault_d,
    output logic [31:0]      fetch_cnt
);

    logic fault_f;

    pc_reg #(
        .PC_RESET (PC_RESET),
        .IM_AW    (IM_AW)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .redirect (redirect),
        .target   (target),
        .pc       (pc_f),
        .fault    (fault_f)
    );

    assign im_addr = pc_f[IM_AW+1:2];

    // Redirect never touches IF/ID: the instruction in F is the delay slot.
    // Flush wins over stall so a squashed slot cannot linger while PC holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_d   <= NOP;
            pc_d      <= PC_RESET;
            pc8_d     <= PC_RESET + 32'd8;
            valid_d   <= 1'b0;
            fault_d   <= 1'b0;
            fetch_cnt <= 32'd0;
        end else if (flush) begin
            instr_d <= NOP;
            pc_d    <= pc_f;
            pc8_d   <= pc_f + 32'd8;
            valid_d <= 1'b0;
            fault_d <= 1'b0;
        end else if (!stall) begin
            instr_d <= fault_f ? NOP : im_instr;
            pc_d    <= pc_f;
            pc8_d   <= pc_f + 32'd8;
            valid_d <= ~fault_f;
            fault_d <= fault_f;
            if (!fault_f) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage against a reference model
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = 32'd0;
    logic [9:0]  im_addr;
    logic [31:0] im_instr;
    logic [31:0] pc_f, instr_d, pc_d, pc8_d, fetch_cnt;
    logic        valid_d, fault_d;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int failures = 0;

    // reference state
    logic [31:0] m_pc, m_instr, m_pc_d, m_pc8, m_cnt;
    logic        m_valid, m_fault;

    always #5 clk = ~clk;

    assign im_instr = mem[im_addr];

    if_stage dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .redirect  (redirect),
        .target    (target),
        .im_addr   (im_addr),
        .im_instr  (im_instr),
        .pc_f      (pc_f),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pc8_d     (pc8_d),
        .valid_d   (valid_d),
        .fault_d   (fault_d),
        .fetch_cnt (fetch_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory image is only indexed by the low word-address bits of the PC.
    function automatic logic [31:0] word_at(input logic [31:0] pc);
        int idx;
        idx = int'((pc / 4) % 1024);
        return mem[idx];
    endfunction

    function automatic logic bad_pc(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc / 4096 != 32'h3);
    endfunction

    task automatic model_update();
        logic        f;
        logic [31:0] w;
        f = bad_pc(m_pc);
        w = word_at(m_pc);
        if (!reset) begin
            m_pc = 32'h3000; m_instr = 0; m_pc_d = 32'h3000; m_pc8 = 32'h3008;
            m_valid = 0; m_fault = 0; m_cnt = 0;
            return;
        end
        if (flush) begin
            m_instr = 0; m_valid = 0; m_fault = 0;
            m_pc_d = m_pc; m_pc8 = m_pc + 8;
        end else if (!stall) begin
            m_instr = f ? 32'd0 : w;
            m_valid = !f; m_fault = f;
            m_pc_d = m_pc; m_pc8 = m_pc + 8;
            if (!f) m_cnt = m_cnt + 1;
        end
        if (!stall) m_pc = redirect ? target : m_pc + 4;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("pc_f", pc_f, m_pc);
        check("im_addr", {22'd0, im_addr}, (m_pc / 4) % 1024);
        check("instr_d", instr_d, m_instr);
        check("pc_d", pc_d, m_pc_d);
        check("pc8_d", pc8_d, m_pc8);
        check("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
        check("fault_d", {31'd0, fault_d}, {31'd0, m_fault});
        check("fetch_cnt", fetch_cnt, m_cnt);
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic rd, input logic [31:0] t);
        reset = r; stall = s; flush = f; redirect = rd; target = t;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        m_pc = 32'h3000;
        m_instr = 0; m_pc_d = 0; m_pc8 = 0; m_valid = 0; m_fault = 0; m_cnt = 0;

        // reset
        drive(0, 0, 0, 0, 0);
        step(); step();
        check("rst_pc_f", pc_f, 32'h3000);
        check("rst_pc8_d", pc8_d, 32'h3008);
        check("rst_cnt", fetch_cnt, 32'd0);

        // sequential fetch
        drive(1, 0, 0, 0, 0);
        step();
        check("seq_pc_d0", pc_d, 32'h3000);
        check("seq_im_addr1", {22'd0, im_addr}, 32'd1);
        step();
        check("seq_pc_d1", pc_d, 32'h3004);
        check("seq_cnt2", fetch_cnt, 32'd2);

        // redirect with delay slot at 0x3008
        drive(1, 0, 0, 1, 32'h3040);
        step();
        check("redir_pc", pc_f, 32'h3040);
        check("delay_slot", instr_d, mem[2]);

        // stall with redirect held: ignored
        drive(1, 1, 0, 1, 32'h3100);
        step(); step(); step();
        check("stall_pc", pc_f, 32'h3040);
        check("stall_cnt", fetch_cnt, 32'd3);
        drive(1, 0, 0, 0, 0);
        step();
        check("release_pc", pc_f, 32'h3044);

        // flush together with stall
        drive(1, 1, 1, 0, 0);
        step();
        check("flush_valid", {31'd0, valid_d}, 32'd0);
        check("flush_pc", pc_f, 32'h3044);
        check("flush_cnt", fetch_cnt, 32'd4);

        // misaligned, then out-of-window
        drive(1, 0, 0, 1, 32'h3002);
        step();
        drive(1, 0, 0, 1, 32'h4000);
        step();
        check("mis_fault", {31'd0, fault_d}, 32'd1);
        drive(1, 0, 0, 0, 0);
        step();
        check("oow_fault", {31'd0, fault_d}, 32'd1);
        check("oow_pc", pc_f, 32'h4004);

        // reset mid-stall
        drive(1, 0, 0, 1, 32'h3020);
        step();
        drive(1, 1, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 0);
        step();
        check("midstall_rst_pc", pc_f, 32'h3000);
        check("midstall_rst_valid", {31'd0, valid_d}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] t;
            case ($urandom % 8)
                0: t = 32'h3000 | ($urandom & 32'hFFF);
                1: t = $urandom;
                default: t = 32'h3000 + (($urandom % 1024) << 2);
            endcase
            drive(($urandom % 50) != 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                  ($urandom % 5) == 0, t);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
